uart_fifo_core: RTL
===================

// Module: uart_fifo_core
// PURPOSE
//  Parametrised UART core: TX serializer and RX deserializer, each behind a first-word-fall-through FIFO.
//  Configurable data width, baud divisor, parity mode and FIFO depth; optional echo mode returns received words.
//  Sits between the board serial pins and user logic as the single UART instance of the top level.
//  One clock domain; all user-side handshakes are valid/ready.
// PARAMETERS
//  DATA_BITS     8    word width, 5..9; serialised LSB first
//  CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); must be >= 4
//  PARITY        0    0 = none, 1 = even, 2 = odd
//  FIFO_DEPTH    16   entries per FIFO; power of two, >= 2
//  LVL_W         5    $clog2(FIFO_DEPTH)+1, width of level outputs
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  uart_rxd_in    in   1          serial line in, idle high, asynchronous to clk
//  uart_txd_out   out  1          serial line out, idle high
//  tx_data        in   DATA_BITS  word to transmit
//  tx_valid       in   1          tx_data valid
//  tx_ready       out  1          TX FIFO accepts; forced 0 while echo_en
//  rx_data        out  DATA_BITS  head of RX FIFO
//  rx_valid       out  1          RX FIFO non-empty
//  rx_ready       in   1          consumer pops head when rx_valid & rx_ready
//  echo_en        in   1          1 = good RX words go to TX FIFO instead of RX FIFO
//  rx_parity_err  out  1          1-cycle pulse: parity mismatch, word dropped
//  rx_frame_err   out  1          1-cycle pulse: stop bit sampled 0, word dropped
//  rx_overrun     out  1          1-cycle pulse: destination FIFO full, word dropped
//  tx_level       out  LVL_W      TX FIFO occupancy 0..FIFO_DEPTH
//  rx_level       out  LVL_W      RX FIFO occupancy 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset: uart_txd_out=1, tx_ready=0 during rst then 1, rx_valid=0, rx_data=0, levels=0, error pulses=0.
//  Reset mid-frame: both FIFOs emptied; TX line is 1 on the cycle after rst is sampled.
//  RX must see >=1 synchronised high sample after reset before it arms, so a partial frame is never taken.
//  FIFOs: push only when not full; pop only when not empty. Push+pop in one cycle leaves level unchanged.
//  tx_ready = !tx_full & !echo_en. Pointers wrap modulo FIFO_DEPTH.
//  TX FSM IDLE->START->DATA(DATA_BITS)->PARITY (skipped if PARITY=0)->STOP->IDLE.
//  Each TX state lasts exactly CLKS_PER_BIT cycles. The STOP bit is a single stop bit.
//  TX latency: word accepted at edge N with TX FIFO empty and FSM idle -> uart_txd_out falls at edge N+2.
//  Back-to-back TX: the next word's START follows STOP with no idle bit.
//  RX input: 2-flop synchroniser. IDLE waits for a synchronised 0.
//  RX START: sample at CLKS_PER_BIT/2; a 1 there is a glitch -> back to IDLE with no pulse.
//  RX then samples the centre of each DATA, PARITY and STOP bit, one CLKS_PER_BIT apart.
//  RX at the STOP-sample cycle, decision priority: frame_err > parity_err > overrun > push.
//  Only one pulse per frame. RX returns to IDLE immediately and is ready for the next start edge.
//  Parity: even means data^parity bits XOR to 0; odd means they XOR to 1.
//  Echo: while echo_en=1, good words push into the TX FIFO; rx_overrun fires if the TX FIFO is full.
//  echo_en is sampled at the STOP-sample cycle; toggling it mid-frame is legal.
//  Unused upper bits: rx_data is zero-extended only within DATA_BITS; there are no hidden bits.
// TESTING (sim: CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4)
//  Write 0xA5 to an idle core -> uart_txd_out low at N+2.
//    Then bits 1,0,1,0,0,1,0,1, stop 1; each bit 16 cycles; tx_level 1->0.
//  Drive 0x3C frame on uart_rxd_in -> rx_valid rises with rx_data=0x3C.
//    rx_ready=1 pops it; rx_level 1->0.
//  PARITY=1, send 0x07 with parity bit 0 -> rx_parity_err pulses once; rx_level stays 0.
//  Stop bit driven 0 -> rx_frame_err pulse. A 4-cycle low glitch on idle line -> no pulse, no word.
//  Receive 5 frames with rx_ready=0 -> rx_level=4; 5th frame gives rx_overrun; FIFO holds the first 4 words.
//  echo_en=1, receive 0x55 -> tx_ready=0, rx_level=0; 0x55 is retransmitted on uart_txd_out.
//  Assert rst mid-TX-frame -> next cycle uart_txd_out=1 and tx_level=0.

Source files
------------

// File: rtl/uart_fifo_core.sv
// UART core: TX serializer and RX deserializer, each behind a FWFT FIFO.
// Ports: clk/rst (sync, active-high), uart_rxd_in/uart_txd_out serial pins,
//   tx_data/tx_valid/tx_ready user TX handshake, rx_data/rx_valid/rx_ready
//   user RX handshake, echo_en loopback select, rx_parity_err/rx_frame_err/
//   rx_overrun one-cycle error pulses, tx_level/rx_level FIFO occupancy.

module uart_fifo_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    output logic [W-1:0]     o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [LVL_W-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LVL_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
    assign o_level = r_cnt;
    assign o_dout  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH by overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd_in,
    output logic                 uart_txd_out,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 echo_en,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic [LVL_W-1:0]     tx_level,
    output logic [LVL_W-1:0]     rx_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 2);
    localparam logic          HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] w_txf_head;
    logic [DATA_BITS-1:0] w_txf_din;
    logic                 w_txf_push;
    logic                 w_txf_empty;
    logic                 w_txf_full;
    logic                 w_tx_pop;
    logic [DATA_BITS-1:0] w_rxf_head;
    logic                 w_rxf_empty;
    logic                 w_rxf_full;
    logic                 w_rx_push;
    logic                 w_echo_push;
    logic [DATA_BITS-1:0] r_rx_sh;

    assign tx_ready   = ~rst & ~w_txf_full & ~echo_en;
    assign w_txf_push = (tx_valid & tx_ready) | w_echo_push;
    assign w_txf_din  = w_echo_push ? r_rx_sh : tx_data;
    assign rx_valid   = ~w_rxf_empty;
    assign rx_data    = rx_valid ? w_rxf_head : '0;

    uart_fifo_core_fifo #(
        .W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
    ) u_txf (
        .clk(clk), .rst(rst),
        .i_push(w_txf_push), .i_din(w_txf_din), .i_pop(w_tx_pop),
        .o_dout(w_txf_head), .o_empty(w_txf_empty),
        .o_full(w_txf_full), .o_level(tx_level)
    );

    uart_fifo_core_fifo #(
        .W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
    ) u_rxf (
        .clk(clk), .rst(rst),
        .i_push(w_rx_push), .i_din(r_rx_sh), .i_pop(rx_ready),
        .o_dout(w_rxf_head), .o_empty(w_rxf_empty),
        .o_full(w_rxf_full), .o_level(rx_level)
    );

    // ---------------- TX ----------------
    state_t               r_tx_st;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx_par;
    logic                 r_txd;
    logic                 w_tx_end;

    assign w_tx_end = (r_tx_cnt == CNT_END);
    // Pop from idle, or at the end of STOP so frames run back-to-back.
    assign w_tx_pop = ~w_txf_empty &
                      ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_end));
    assign uart_txd_out = r_txd;

    // The line register follows the state one cycle later, which gives the
    // two-edge accept-to-start latency while keeping every bit full length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx_par <= 1'b0;
            r_txd    <= 1'b1;
        end else begin
            case (r_tx_st)
                S_START: r_txd <= 1'b0;
                S_DATA:  r_txd <= r_tx_sh[0];
                S_PAR:   r_txd <= r_tx_par;
                default: r_txd <= 1'b1;
            endcase
            case (r_tx_st)
                S_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_sh  <= w_txf_head;
                        r_tx_par <= (^w_txf_head) ^ ODD;
                        r_tx_st  <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_tx_st  <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        r_tx_sh  <= r_tx_sh >> 1;
                        if (r_tx_bit == BIT_LAST)
                            r_tx_st <= HAS_PAR ? S_PAR : S_STOP;
                        else
                            r_tx_bit <= r_tx_bit + 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        r_tx_st  <= S_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_sh  <= w_txf_head;
                            r_tx_par <= (^w_txf_head) ^ ODD;
                            r_tx_st  <= S_START;
                        end else begin
                            r_tx_st <= S_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX ----------------
    state_t        r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [BW-1:0] r_rx_bit;
    logic          r_s1;
    logic          r_s2;
    logic          r_armed;
    logic          r_rx_perr;
    logic          r_perr_p;
    logic          r_ferr_p;
    logic          r_ovr_p;
    logic          w_rx_end;
    logic          w_stop_smp;
    logic          w_dst_full;
    logic          w_rx_good;

    assign w_rx_end    = (r_rx_cnt == CNT_END);
    assign w_stop_smp  = (r_rx_st == S_STOP) & w_rx_end;
    assign w_dst_full  = echo_en ? w_txf_full : w_rxf_full;
    assign w_rx_good   = w_stop_smp & r_s2 & ~r_rx_perr & ~w_dst_full;
    assign w_rx_push   = w_rx_good & ~echo_en;
    assign w_echo_push = w_rx_good & echo_en;

    assign rx_parity_err = r_perr_p;
    assign rx_frame_err  = r_ferr_p;
    assign rx_overrun    = r_ovr_p;

    // Synchroniser resets low so a genuine idle-high must be seen before
    // the receiver arms; a frame already in flight at reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_armed   <= 1'b0;
            r_rx_st   <= S_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_perr <= 1'b0;
            r_perr_p  <= 1'b0;
            r_ferr_p  <= 1'b0;
            r_ovr_p   <= 1'b0;
        end else begin
            r_s1     <= uart_rxd_in;
            r_s2     <= r_s1;
            r_perr_p <= 1'b0;
            r_ferr_p <= 1'b0;
            r_ovr_p  <= 1'b0;
            if (r_s2) r_armed <= 1'b1;
            case (r_rx_st)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_armed & ~r_s2) r_rx_st <= S_START;
                end
                S_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt  <= '0;
                        r_rx_bit  <= '0;
                        r_rx_perr <= 1'b0;
                        r_rx_st   <= r_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_end) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_s2, r_rx_sh[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_LAST)
                            r_rx_st <= HAS_PAR ? S_PAR : S_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_rx_end) begin
                        r_rx_cnt  <= '0;
                        r_rx_perr <= ((^r_rx_sh) ^ r_s2) != ODD;
                        r_rx_st   <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_rx_end) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= S_IDLE;
                        // One pulse per frame: frame > parity > overrun.
                        r_ferr_p <= ~r_s2;
                        r_perr_p <= r_s2 & r_rx_perr;
                        r_ovr_p  <= r_s2 & ~r_rx_perr & w_dst_full;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end
endmodule
